// File: rtl/icache_axi_rd.sv
// AXI4 read master for instruction-cache refills: one full-line INCR burst
// (cached) or a single word (uncached), assembled into a cacheline buffer.
module icache_axi_rd #(
  parameter int         LINE_WORDS = 8,
  parameter logic [3:0] AXI_ID     = 4'd0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rreq_i,
  input  logic [31:0]                raddr_i,
  input  logic                       cached_i,
  output logic                       rend_o,
  output logic [LINE_WORDS*32-1:0]   cacheline_rdata_o,
  output logic                       err_o,
  output logic                       busy_o,
  output logic [3:0]                 arid_o,
  output logic [31:0]                araddr_o,
  output logic [7:0]                 arlen_o,
  output logic [2:0]                 arsize_o,
  output logic [1:0]                 arburst_o,
  output logic                       arvalid_o,
  input  logic                       arready_i,
  input  logic [31:0]                rdata_i,
  input  logic [1:0]                 rresp_i,
  input  logic                       rlast_i,
  input  logic                       rvalid_i,
  output logic                       rready_o
);

  localparam int              CW        = $clog2(LINE_WORDS);
  localparam logic [31:0]     LINE_MASK = ~(32'(LINE_WORDS * 4) - 32'd1);
  localparam logic [CW-1:0]   LAST_BEAT = CW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_e;

  state_e                       state_q, state_d;
  logic [31:0]                  araddr_q, araddr_d;
  logic [7:0]                   arlen_q, arlen_d;
  logic                         cached_q, cached_d;
  logic [CW-1:0]                beat_q, beat_d;
  logic                         err_q, err_d;
  logic [LINE_WORDS-1:0][31:0]  line_q, line_d;

  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    cached_d = cached_q;
    beat_d   = beat_q;
    err_d    = err_q;
    line_d   = line_q;
    unique case (state_q)
      IDLE: begin
        if (rreq_i) begin
          state_d  = AR;
          araddr_d = cached_i ? (raddr_i & LINE_MASK) : {raddr_i[31:2], 2'b00};
          arlen_d  = cached_i ? 8'(LINE_WORDS - 1) : 8'd0;
          cached_d = cached_i;
          beat_d   = '0;
          err_d    = 1'b0;
          line_d   = '0;
        end
      end
      AR: begin
        if (arready_i) state_d = AR == AR ? R : R;
      end
      R: begin
        if (rvalid_i) begin
          line_d[beat_q] = rdata_i;
          beat_d         = beat_q + 1'b1;
          if (rresp_i != 2'b00) err_d = 1'b1;
          // Whichever comes first ends the burst: rlast, a full line, or the lone uncached beat.
          if (rlast_i || !cached_q || beat_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= IDLE;
      araddr_q <= '0;
      arlen_q  <= '0;
      cached_q <= 1'b0;
      beat_q   <= '0;
      err_q    <= 1'b0;
      line_q   <= '0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      cached_q <= cached_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
      line_q   <= line_d;
    end
  end

  assign arvalid_o         = (state_q == AR);
  assign rready_o          = (state_q == R);
  assign rend_o            = (state_q == DONE);
  assign busy_o            = (state_q != IDLE);
  assign err_o             = err_q;
  assign araddr_o          = araddr_q;
  assign arlen_o           = arlen_q;
  assign arsize_o          = 3'b010;
  assign arburst_o         = 2'b01;
  assign arid_o            = AXI_ID;
  assign cacheline_rdata_o = line_q;

endmodule
